fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue between the program counter register and the decode stage. Each cycle it may issue the current PC to the synchronous instruction memory. The returned word is captured together with its PC into a small FIFO and presented to decode over a valid/ready handshake. The block backpressures the PC register through its hold input and discards all queued and in-flight fetches on a control-flow redirect.

## Interface
- NB_ADDR, 32 (`ADDRWIDTH`): PC / instruction-memory address width
- NB_INSTR, 32: instruction word width
- DEPTH, 4: FIFO entries; power of two, ≥ 2
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_pc  in  NB_ADDR  current PC from the PC register
- o_pc_stall  out  1  high = PC register holds its value (drives its hold/enable input)
- o_imem_en  out  1  fetch request to instruction memory this cycle
- o_imem_addr  out  NB_ADDR  fetch address, combinationally equal to i_pc
- i_imem_data  in  NB_INSTR  memory read data, valid exactly 1 cycle after o_imem_en
- i_flush  in  1  redirect (taken branch/jump): discard queue and in-flight fetch
- o_valid  out  1  head entry available to decode
- o_instr  out  NB_INSTR  head instruction
- o_instr_pc  out  NB_ADDR  PC of head instruction
- i_ready  in  1  decode accepts head this cycle
- o_count  out  clog2(DEPTH)+1  occupied entries, 0..DEPTH

## Operation
- State: FIFO storage (instr + pc per entry), rd/wr pointers of clog2(DEPTH) bits wrapping modulo DEPTH, count register, in-flight flag `infl` plus in-flight PC register.
- Issue condition: `issue = i_reset & ~i_flush & (count + infl < DEPTH)`, evaluated on registered count/infl with no pop lookahead.
- o_imem_en = issue; o_pc_stall = ~issue & ~i_flush. On flush the PC is released so it can load the redirect target.
- On an issue edge: infl ← 1, in-flight PC ← i_pc. With no issue: infl ← 0.
- Push: when infl = 1 and i_flush = 0, write {i_imem_data, in-flight PC} at wr pointer; wr pointer +1.
- Pop: when o_valid & i_ready & ~i_flush, rd pointer +1.
- count ← count + push − pop. Simultaneous push and pop leaves count unchanged. Overflow cannot occur, because issue is credit-limited.
- o_valid = (count ≠ 0); o_instr/o_instr_pc = entry at rd pointer (combinational read). o_instr/o_instr_pc are don't-care when o_valid = 0.
- Flush has priority over every other event in the same cycle:
  - count ← 0, pointers ← 0, infl ← 0;
  - no push (the returning word is dropped), no pop, no issue.
- Reset (i_reset = 0, any time, including mid-fetch or with the queue full):
  - count, pointers and infl clear immediately;
  - o_valid = 0, o_imem_en = 0, o_pc_stall = 1, o_count = 0;
  - FIFO storage is not cleared.
- First issue occurs in the first cycle after reset deasserts.

## Timing
- Fetch latency: PC issued at edge N, entry written at edge N+1, o_valid high in cycle after N+1. First instruction reaches decode 2 cycles after issue.
- Sustained throughput: 1 instruction/cycle while i_ready = 1 (count ≤ 1, infl = 1, so issue stays enabled).
- Backpressure: with i_ready = 0, issues continue until count + infl = DEPTH. Then o_pc_stall = 1 and the PC holds.
- After i_ready returns to 1, issue resumes the cycle after the first pop lowers count.
- Handshake: o_valid/o_instr stay stable while o_valid & ~i_ready. A transfer occurs only on an edge with o_valid & i_ready.
- Flush at edge F: o_valid = 0 after F. The redirect-target fetch issues at edge F+1, and its instruction is visible after F+2.

## Test plan
- Reset/startup: hold i_reset = 0 for 3 cycles, then release with i_pc = 0x0 and upstream PC+4; i_ready = 1 -> o_valid = 0 and o_pc_stall = 1 during reset. o_valid rises 2 cycles after release, and decode receives PCs 0x0, 0x4, 0x8, 0xC on consecutive cycles with matching memory words.
- Backpressure fill: i_ready = 0 from start, DEPTH = 4 -> o_count reaches 4 and o_pc_stall = 1. The PC holds at 0x10; exactly entries 0x0..0xC are queued and no word is lost or duplicated.
- Drain with simultaneous push/pop: from full, set i_ready = 1 -> o_count goes 4→3 and then holds at a steady 1–2 with push and pop together. The output PC sequence stays contiguous with no gaps.
- Flush mid-stream: queue holding 0x20, 0x24 with a fetch of 0x28 in flight; pulse i_flush with PC redirect to 0x100 -> o_count = 0 and o_valid = 0 next cycle. The 0x28 word is dropped, and the next delivered instruction has o_instr_pc = 0x100.
- Flush with i_ready high and pointers wrapped: run 6 instructions, then flush on a cycle where pop would occur -> no pop is counted, pointers return to 0, and output resumes correctly.
- Asynchronous reset mid-operation: assert i_reset = 0 between clock edges while full -> o_valid, o_imem_en and o_count drop to 0 without waiting for a clock edge. After release, behaviour matches the startup scenario.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues PCs to a 1-cycle synchronous imem and buffers {instr, pc} for decode.
// Credit-limited issue (count + in-flight < DEPTH); a redirect flush drops queued and in-flight fetches.
module fetch_queue #(
  parameter int NB_ADDR  = 32,
  parameter int NB_INSTR = 32,
  parameter int DEPTH    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NB_ADDR-1:0]       i_pc,
  output logic                     o_pc_stall,
  output logic                     o_imem_en,
  output logic [NB_ADDR-1:0]       o_imem_addr,
  input  logic [NB_INSTR-1:0]      i_imem_data,
  input  logic                     i_flush,
  output logic                     o_valid,
  output logic [NB_INSTR-1:0]      o_instr,
  output logic [NB_ADDR-1:0]       o_instr_pc,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [NB_INSTR-1:0] instr_mem [DEPTH];
  logic [NB_ADDR-1:0]  pc_mem    [DEPTH];

  logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               infl_q, infl_d;
  logic [NB_ADDR-1:0] infl_pc_q, infl_pc_d;

  logic [CW:0] used;
  logic        issue, push, pop;

  // A slot is reserved for the in-flight word, so the FIFO can never overflow.
  assign used  = {1'b0, count_q} + {{CW{1'b0}}, infl_q};
  assign issue = i_reset & ~i_flush & (used < DEPTH_C);
  assign push  = infl_q & ~i_flush;
  assign pop   = o_valid & i_ready & ~i_flush;

  assign o_imem_en   = issue;
  assign o_imem_addr = i_pc;
  assign o_pc_stall  = ~issue & ~i_flush;
  assign o_valid     = (count_q != '0);
  assign o_instr     = instr_mem[rd_q];
  assign o_instr_pc  = pc_mem[rd_q];
  assign o_count     = count_q;

  always_comb begin
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    infl_d    = infl_q;
    infl_pc_d = infl_pc_q;
    if (i_flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      infl_d  = 1'b0;
    end else begin
      infl_d = issue;
      if (issue) infl_pc_d = i_pc;
      if (push)  wr_d = wr_q + PW'(1);
      if (pop)   rd_d = rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_mem[wr_q] <= i_imem_data;
      pc_mem[wr_q]    <= infl_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue with a queue-based reference model of the fetch/deliver stream.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_stall;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        flush;
  logic [31:0] flush_tgt;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ready;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.NB_ADDR(32), .NB_INSTR(32), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_pc(pc), .o_pc_stall(pc_stall),
    .o_imem_en(imem_en), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .i_flush(flush), .o_valid(valid), .o_instr(instr), .o_instr_pc(instr_pc),
    .i_ready(ready), .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
  endfunction

  // Upstream PC register and synchronous instruction memory.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pc <= 32'h0;
    else if (flush)     pc <= flush_tgt;
    else if (!pc_stall) pc <= pc + 32'd4;
  end

  always @(posedge clk) if (imem_en) imem_data <= mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_pend = 1'b0;
  endtask

  task automatic step(input logic r, input logic f, input logic rdy, input logic [31:0] tgt);
    bit   e_valid, e_issue;
    ent_t e;
    @(negedge clk);
    rst_n = r; flush = f; ready = rdy; flush_tgt = tgt;
    if (!r) model_clear();
    #1;
    e_valid = (mq.size() != 0);
    e_issue = r && !f && (mq.size() + int'(m_pend) < DEPTH);
    chk("valid", 64'(valid), 64'(e_valid));
    chk("count", 64'(count), 64'(mq.size()));
    chk("imem_en", 64'(imem_en), 64'(e_issue));
    chk("pc_stall", 64'(pc_stall), 64'(!e_issue && !f));
    chk("imem_addr", 64'(imem_addr), 64'(pc));
    if (e_valid) begin
      chk("instr_pc", 64'(instr_pc), 64'(mq[0].pc));
      chk("instr", 64'(instr), 64'(mq[0].ins));
    end
    if (r) begin
      if (f) begin
        model_clear();
      end else begin
        if (e_valid && rdy) void'(mq.pop_front());
        if (m_pend) begin
          e.pc  = m_pend_pc;
          e.ins = mem_word(m_pend_pc);
          mq.push_back(e);
        end
        m_pend    = e_issue;
        m_pend_pc = pc;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ready = 1'b1; flush_tgt = 32'h0;
    model_clear();

    // Reset held, then startup streaming with decode always ready.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 32'h0);

    // Backpressure fill from a fresh start, then drain.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("bp_count", 64'(count), 64'd4);
    chk("bp_pc_hold", 64'(pc), 64'h10);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 32'h0);

    // Mid-stream redirect to 0x100 while decode is stalled.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 32'h0);

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 400; i++)
      step(1'b1, ($urandom % 12) == 0, ($urandom % 4) != 0, 32'($urandom_range(0, 1023)) << 2);

    // Asynchronous reset while full, observed before any clock edge.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_count", 64'(count), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_imem_en", 64'(imem_en), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_pc_stall", 64'(pc_stall), 64'd1);
    model_clear();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 200; i++)
      step(1'b1, ($urandom % 16) == 0, ($urandom % 3) != 0, 32'($urandom_range(0, 1023)) << 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
